pipeline_control_unit: RTL and testbench

- Central sequencer for the 5-stage MIPS pipeline. Generates per-stage write enables, the IF/ID flush and the ID/EX bubble.
- Inputs it arbitrates: the load-use stall request from hazard detection, the branch-taken flush from ID, and the halt-instruction detect.
- Supports free-run and single-step execution under debug-unit control.
- After a halt, drains the pipeline for a fixed number of cycles, then freezes it and counts executed cycles.

---
 rtl/pipeline_control_unit.sv | 112 +++++++++++
 tb/tb_pipeline_control_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pipeline_control_unit.sv
// Central sequencer for the 5-stage pipeline: stage enables, IF/ID flush, ID/EX bubble,
// free-run / single-step control, and the post-halt drain with an executed-cycle counter.
module pipeline_control_unit #(
  parameter int DRAIN_CYCLES = 4,
  parameter int NB_DRAIN     = 4,
  parameter int NB_CYCLES    = 32
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_step_mode,
  input  logic                 i_step,
  input  logic                 i_stall,
  input  logic                 i_branch_taken,
  input  logic                 i_halt_detected,
  output logic                 o_pc_enable,
  output logic                 o_if_id_enable,
  output logic                 o_if_id_flush,
  output logic                 o_id_ex_bubble,
  output logic                 o_pipe_enable,
  output logic                 o_running,
  output logic                 o_halted,
  output logic [NB_CYCLES-1:0] o_cycle_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t                state_reg, state_next;
  logic [NB_DRAIN-1:0]   drain_reg, drain_next;
  logic [NB_CYCLES-1:0]  cycle_reg;
  logic                  advance;

  assign advance       = (state_reg == RUN) || ((state_reg == STEP) && i_step);
  assign o_cycle_count = cycle_reg;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_reg <= IDLE;
      drain_reg <= '0;
      cycle_reg <= '0;
    end else begin
      state_reg <= state_next;
      drain_reg <= drain_next;
      if (o_pipe_enable)
        cycle_reg <= cycle_reg + NB_CYCLES'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    drain_next = drain_reg;
    case (state_reg)
      IDLE: begin
        if (i_start)
          state_next = i_step_mode ? STEP : RUN;
      end
      RUN, STEP: begin
        // A halt only counts when it is not masked by a stall or a taken branch.
        if (advance && !i_stall && !i_branch_taken && i_halt_detected) begin
          state_next = DRAIN;
          drain_next = NB_DRAIN'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (drain_reg == '0)
          state_next = HALTED;
        else
          drain_next = drain_reg - NB_DRAIN'(1);
      end
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_pc_enable    = 1'b0;
    o_if_id_enable = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_pipe_enable  = 1'b0;
    o_running      = (state_reg == RUN) || (state_reg == STEP) || (state_reg == DRAIN);
    o_halted       = (state_reg == HALTED);
    if (advance) begin
      o_pipe_enable = 1'b1;
      if (i_stall) begin
        o_id_ex_bubble = 1'b1;
      end else if (i_branch_taken) begin
        o_pc_enable    = 1'b1;
        o_if_id_enable = 1'b1;
        o_if_id_flush  = 1'b1;
      end else if (i_halt_detected) begin
        o_if_id_enable = 1'b1;
        o_if_id_flush  = 1'b1;
      end else begin
        o_pc_enable    = 1'b1;
        o_if_id_enable = 1'b1;
      end
    end else if (state_reg == DRAIN) begin
      // Keep retiring in-flight instructions while feeding NOPs behind them.
      o_if_id_enable = 1'b1;
      o_if_id_flush  = 1'b1;
      o_pipe_enable  = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit; a second instance with a 4-bit counter checks wrap.
module tb_pipeline_control_unit;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_step_mode = 1'b0;
  logic        i_step = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_branch_taken = 1'b0;
  logic        i_halt_detected = 1'b0;
  logic        o_pc_enable, o_if_id_enable, o_if_id_flush, o_id_ex_bubble;
  logic        o_pipe_enable, o_running, o_halted;
  logic [31:0] o_cycle_count;
  logic        w_pc_enable, w_if_id_enable, w_if_id_flush, w_id_ex_bubble;
  logic        w_pipe_enable, w_running, w_halted;
  logic [3:0]  w_cycle_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_count = '0;
  logic [6:0]  sb[$];

  // {pc_en, if_id_en, flush, bubble, pipe_en, running, halted}
  localparam logic [6:0] E_IDLE  = 7'b0000000;
  localparam logic [6:0] E_RUN   = 7'b1100110;
  localparam logic [6:0] E_STALL = 7'b0001110;
  localparam logic [6:0] E_BR    = 7'b1110110;
  localparam logic [6:0] E_HALT  = 7'b0110110;
  localparam logic [6:0] E_DRAIN = 7'b0110110;
  localparam logic [6:0] E_SWAIT = 7'b0000010;
  localparam logic [6:0] E_HLTD  = 7'b0000001;

  always #5 i_clock = ~i_clock;

  pipeline_control_unit #(.DRAIN_CYCLES(4), .NB_DRAIN(4), .NB_CYCLES(32)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_step_mode(i_step_mode),
    .i_step(i_step), .i_stall(i_stall), .i_branch_taken(i_branch_taken),
    .i_halt_detected(i_halt_detected), .o_pc_enable(o_pc_enable),
    .o_if_id_enable(o_if_id_enable), .o_if_id_flush(o_if_id_flush),
    .o_id_ex_bubble(o_id_ex_bubble), .o_pipe_enable(o_pipe_enable),
    .o_running(o_running), .o_halted(o_halted), .o_cycle_count(o_cycle_count)
  );

  pipeline_control_unit #(.DRAIN_CYCLES(4), .NB_DRAIN(4), .NB_CYCLES(4)) dut4 (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_step_mode(i_step_mode),
    .i_step(i_step), .i_stall(i_stall), .i_branch_taken(i_branch_taken),
    .i_halt_detected(i_halt_detected), .o_pc_enable(w_pc_enable),
    .o_if_id_enable(w_if_id_enable), .o_if_id_flush(w_if_id_flush),
    .o_id_ex_bubble(w_id_ex_bubble), .o_pipe_enable(w_pipe_enable),
    .o_running(w_running), .o_halted(w_halted), .o_cycle_count(w_cycle_count)
  );

  // One clock cycle: drive inputs at the falling edge, check outputs 1ns later, then model the rising edge.
  task automatic cyc(input string tag, input logic rst, input logic st, input logic sm,
                     input logic stp, input logic stl, input logic br, input logic hlt,
                     input logic [6:0] exp);
    logic [6:0] obs, e;
    @(negedge i_clock);
    i_reset = rst; i_start = st; i_step_mode = sm; i_step = stp;
    i_stall = stl; i_branch_taken = br; i_halt_detected = hlt;
    sb.push_back(exp);
    #1;
    obs = {o_pc_enable, o_if_id_enable, o_if_id_flush, o_id_ex_bubble,
           o_pipe_enable, o_running, o_halted};
    e = sb.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s outputs: observed=%b expected=%b", tag, obs, e);
    end
    total++;
    assert (o_cycle_count === exp_count) else begin
      bad++;
      $error("FAIL %s count: observed=%0d expected=%0d", tag, o_cycle_count, exp_count);
    end
    total++;
    assert (w_cycle_count === exp_count[3:0]) else begin
      bad++;
      $error("FAIL %s count4: observed=%0d expected=%0d", tag, w_cycle_count, exp_count[3:0]);
    end
    $display("cycle %-12s in rst=%b st=%b sm=%b stp=%b stl=%b br=%b hlt=%b out=%b cnt=%0d",
             tag, rst, st, sm, stp, stl, br, hlt, obs, o_cycle_count);
    @(posedge i_clock);
    if (!rst) exp_count = '0;
    else if (e[2]) exp_count = exp_count + 32'd1;
  endtask

  initial begin
    // reset and idle
    repeat (2) cyc("reset", 0, 0, 0, 0, 0, 0, 0, E_IDLE);
    repeat (3) cyc("idle", 1, 0, 0, 0, 1, 1, 1, E_IDLE);
    cyc("start_run", 1, 1, 0, 0, 0, 0, 0, E_IDLE);
    cyc("run", 1, 0, 0, 0, 0, 0, 0, E_RUN);
    cyc("run_stray", 1, 1, 1, 1, 0, 0, 0, E_RUN);
    // stall / branch priority
    cyc("stall", 1, 0, 0, 0, 1, 0, 0, E_STALL);
    cyc("stall_br", 1, 0, 0, 0, 1, 1, 0, E_STALL);
    cyc("branch", 1, 0, 0, 0, 0, 1, 0, E_BR);
    cyc("br_halt", 1, 0, 0, 0, 0, 1, 1, E_BR);
    cyc("stall_halt", 1, 0, 0, 0, 1, 0, 1, E_STALL);
    cyc("run", 1, 0, 0, 0, 0, 0, 0, E_RUN);
    // halt and drain
    cyc("halt", 1, 0, 0, 0, 0, 0, 1, E_HALT);
    cyc("drain1", 1, 0, 0, 0, 0, 0, 0, E_DRAIN);
    cyc("drain2_stl", 1, 0, 0, 0, 1, 1, 1, E_DRAIN);
    cyc("drain3", 1, 0, 0, 0, 0, 0, 0, E_DRAIN);
    cyc("drain4", 1, 0, 0, 0, 0, 0, 0, E_DRAIN);
    cyc("halted", 1, 1, 0, 1, 0, 0, 0, E_HLTD);
    cyc("halted", 1, 1, 1, 0, 0, 1, 1, E_HLTD);
    // single-step mode
    cyc("reset", 0, 0, 0, 0, 0, 0, 0, E_HLTD);
    cyc("start_step", 1, 1, 1, 0, 0, 0, 0, E_IDLE);
    repeat (5) cyc("step_wait", 1, 0, 0, 0, 1, 1, 1, E_SWAIT);
    cyc("step1", 1, 0, 0, 1, 0, 0, 0, E_RUN);
    cyc("step_wait", 1, 0, 0, 0, 0, 0, 0, E_SWAIT);
    cyc("step2", 1, 0, 0, 1, 0, 0, 0, E_RUN);
    cyc("step_wait", 1, 0, 0, 0, 0, 0, 0, E_SWAIT);
    cyc("step3_mode", 1, 0, 0, 1, 0, 0, 0, E_RUN);
    cyc("step_wait", 1, 0, 0, 0, 0, 0, 0, E_SWAIT);
    cyc("step_stall", 1, 0, 0, 1, 1, 0, 0, E_STALL);
    cyc("step_nostall", 1, 0, 0, 1, 0, 0, 0, E_RUN);
    cyc("step_halt", 1, 0, 0, 1, 0, 0, 1, E_HALT);
    repeat (4) cyc("step_drain", 1, 0, 0, 0, 0, 0, 0, E_DRAIN);
    cyc("step_halted", 1, 0, 0, 1, 0, 0, 0, E_HLTD);
    // reset in the middle of DRAIN
    cyc("reset", 0, 0, 0, 0, 0, 0, 0, E_HLTD);
    cyc("start_run", 1, 1, 0, 0, 0, 0, 0, E_IDLE);
    cyc("halt", 1, 0, 0, 0, 0, 0, 1, E_HALT);
    cyc("drain1", 1, 0, 0, 0, 0, 0, 0, E_DRAIN);
    cyc("drain2_rst", 0, 0, 0, 0, 0, 0, 0, E_DRAIN);
    cyc("idle_after", 1, 0, 0, 0, 0, 0, 0, E_IDLE);
    // counter wrap on the 4-bit instance
    cyc("start_run", 1, 1, 0, 0, 0, 0, 0, E_IDLE);
    repeat (17) cyc("wrap_run", 1, 0, 0, 0, 0, 0, 0, E_RUN);
    @(negedge i_clock);
    total++;
    assert (w_cycle_count === 4'd1) else begin
      bad++;
      $error("FAIL wrap_final: observed=%0d expected=1", w_cycle_count);
    end
    total++;
    assert (o_cycle_count === 32'd17) else begin
      bad++;
      $error("FAIL run17_final: observed=%0d expected=17", o_cycle_count);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
